// File: rtl/mac_sequencer.sv
// -----------------------------------------------------------------------------
// mac_sequencer
//
// Runs one dot product per accepted start request on the SRC datapath MAC:
// coefficients are read from ascending addresses, samples from a circular
// buffer walked downwards from the newest sample. After the last product the
// MAC pipeline is flushed, the quantised result and residue words are read back
// through the MAC output mux, latched, and presented with a one-cycle valid.
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   start, abort         job request / synchronous cancel of a running job
//   ntaps                product count (clamped to 2^COEF_AW), sampled at accept
//   coef_base, smp_base  first coefficient / newest sample address
//   init_val             accumulator preload value
//   busy                 high in every state except IDLE
//   coef_rd_en/addr      coefficient RAM read port (data one cycle later)
//   smp_rd_en/addr       sample RAM read port (data one cycle later)
//   mac_*                MAC control, operands and readback
//   result, err, ovr     latched result, residue and sticky overflow
//   result_valid         one-cycle pulse when result/err/ovr are fresh
// -----------------------------------------------------------------------------
module mac_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int COEF_AW    = 8,
    parameter int SMP_AW     = 8,
    parameter int TAPS_W     = 9,
    parameter int MAC_LAT    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [TAPS_W-1:0]     ntaps,
    input  logic [COEF_AW-1:0]    coef_base,
    input  logic [SMP_AW-1:0]     smp_base,
    input  logic [DATA_WIDTH-1:0] init_val,
    output logic                  busy,
    output logic                  coef_rd_en,
    output logic [COEF_AW-1:0]    coef_addr,
    input  logic [DATA_WIDTH-1:0] coef_rdata,
    output logic                  smp_rd_en,
    output logic [SMP_AW-1:0]     smp_addr,
    input  logic [DATA_WIDTH-1:0] smp_rdata,
    output logic                  mac_cen,
    output logic                  mac_init,
    output logic                  mac_load,
    output logic                  mac_res_err,
    output logic [DATA_WIDTH-1:0] mac_op1,
    output logic [DATA_WIDTH-1:0] mac_op2,
    input  logic [DATA_WIDTH-1:0] mac_out_res,
    input  logic                  mac_acc_ovr,
    output logic [DATA_WIDTH-1:0] result,
    output logic [DATA_WIDTH-1:0] err,
    output logic                  ovr,
    output logic                  result_valid
);

    // state  | meaning
    // IDLE   | waiting for start; all strobes low
    // INIT   | preload accumulator with init_val, issue read 0
    // FEED   | one product per cycle from the previous cycle's read data
    // FLUSH  | MAC_LAT zero-operand cycles to drain the MAC pipeline
    // LOAD   | MAC latches its quantised result/residue
    // RES    | read result word through the MAC output mux
    // ERR    | read residue word through the MAC output mux
    // DONE   | result_valid pulse, back to IDLE

    localparam int unsigned MAX_TAPS = 1 << COEF_AW;
    localparam int          CNT_W    = COEF_AW + 1;
    localparam int          FL_W     = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_FEED,
        S_FLUSH,
        S_LOAD,
        S_RES,
        S_ERR,
        S_DONE
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        ntaps_clamped;
    logic [CNT_W-1:0]        feed_cnt;
    logic [FL_W-1:0]         flush_cnt;
    logic [DATA_WIDTH-1:0]   init_q;
    logic                    busy_q;
    logic                    coef_rd_q;
    logic                    smp_rd_q;
    logic                    cen_q;
    logic                    init_s_q;
    logic                    load_q;
    logic                    res_err_q;
    logic                    valid_q;
    logic [COEF_AW-1:0]      coef_addr_q;
    logic [SMP_AW-1:0]       smp_addr_q;
    logic [DATA_WIDTH-1:0]   result_q;
    logic [DATA_WIDTH-1:0]   err_q;
    logic                    ovr_q;

    always_comb begin
        if (32'(ntaps) > MAX_TAPS) begin
            ntaps_clamped = CNT_W'(MAX_TAPS);
        end else begin
            ntaps_clamped = CNT_W'(ntaps);
        end
    end

    // feed_cnt counts FEED cycles still to run, including the current one.
    // The read for the next product is issued while more than one product
    // remains after the current one; addresses only step when a read issues,
    // so coef_addr/smp_addr always show base +/- k for read k.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            feed_cnt    <= '0;
            flush_cnt   <= '0;
            init_q      <= '0;
            busy_q      <= 1'b0;
            coef_rd_q   <= 1'b0;
            smp_rd_q    <= 1'b0;
            cen_q       <= 1'b0;
            init_s_q    <= 1'b0;
            load_q      <= 1'b0;
            res_err_q   <= 1'b0;
            valid_q     <= 1'b0;
            coef_addr_q <= '0;
            smp_addr_q  <= '0;
            result_q    <= '0;
            err_q       <= '0;
            ovr_q       <= 1'b0;
        end else if (state != S_IDLE && abort) begin
            state     <= S_IDLE;
            busy_q    <= 1'b0;
            coef_rd_q <= 1'b0;
            smp_rd_q  <= 1'b0;
            cen_q     <= 1'b0;
            init_s_q  <= 1'b0;
            load_q    <= 1'b0;
            res_err_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_INIT;
                        busy_q      <= 1'b1;
                        cen_q       <= 1'b1;
                        init_s_q    <= 1'b1;
                        init_q      <= init_val;
                        ovr_q       <= 1'b0;
                        feed_cnt    <= ntaps_clamped;
                        coef_addr_q <= coef_base;
                        smp_addr_q  <= smp_base;
                        coef_rd_q   <= (ntaps_clamped != '0);
                        smp_rd_q    <= (ntaps_clamped != '0);
                    end
                end

                S_INIT: begin
                    init_s_q <= 1'b0;
                    if (feed_cnt != '0) begin
                        state <= S_FEED;
                        if (feed_cnt > CNT_W'(1)) begin
                            coef_rd_q   <= 1'b1;
                            smp_rd_q    <= 1'b1;
                            coef_addr_q <= coef_addr_q + COEF_AW'(1);
                            smp_addr_q  <= smp_addr_q - SMP_AW'(1);
                        end else begin
                            coef_rd_q <= 1'b0;
                            smp_rd_q  <= 1'b0;
                        end
                    end else begin
                        state     <= S_FLUSH;
                        flush_cnt <= FL_W'(MAC_LAT - 1);
                    end
                end

                S_FEED: begin
                    if (mac_acc_ovr) begin
                        ovr_q <= 1'b1;
                    end
                    if (feed_cnt == CNT_W'(1)) begin
                        state     <= S_FLUSH;
                        flush_cnt <= FL_W'(MAC_LAT - 1);
                        coef_rd_q <= 1'b0;
                        smp_rd_q  <= 1'b0;
                    end else begin
                        feed_cnt <= feed_cnt - CNT_W'(1);
                        if (feed_cnt > CNT_W'(2)) begin
                            coef_rd_q   <= 1'b1;
                            smp_rd_q    <= 1'b1;
                            coef_addr_q <= coef_addr_q + COEF_AW'(1);
                            smp_addr_q  <= smp_addr_q - SMP_AW'(1);
                        end else begin
                            coef_rd_q <= 1'b0;
                            smp_rd_q  <= 1'b0;
                        end
                    end
                end

                S_FLUSH: begin
                    if (mac_acc_ovr) begin
                        ovr_q <= 1'b1;
                    end
                    if (flush_cnt == '0) begin
                        state  <= S_LOAD;
                        load_q <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt - FL_W'(1);
                    end
                end

                S_LOAD: begin
                    if (mac_acc_ovr) begin
                        ovr_q <= 1'b1;
                    end
                    state     <= S_RES;
                    cen_q     <= 1'b0;
                    load_q    <= 1'b0;
                    res_err_q <= 1'b1;
                end

                S_RES: begin
                    state     <= S_ERR;
                    res_err_q <= 1'b0;
                    result_q  <= mac_out_res;
                end

                S_ERR: begin
                    state   <= S_DONE;
                    err_q   <= mac_out_res;
                    valid_q <= 1'b1;
                end

                S_DONE: begin
                    state   <= S_IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // An abort silences every strobe in the very cycle it is raised; the
    // registered strobes are already low in IDLE, so gating there is harmless.
    assign busy         = busy_q;
    assign coef_rd_en   = coef_rd_q & ~abort;
    assign smp_rd_en    = smp_rd_q & ~abort;
    assign coef_addr    = coef_addr_q;
    assign smp_addr     = smp_addr_q;
    assign mac_cen      = cen_q & ~abort;
    assign mac_init     = init_s_q & ~abort;
    assign mac_load     = load_q & ~abort;
    assign mac_res_err  = res_err_q & ~abort;
    assign result_valid = valid_q & ~abort;
    assign result       = result_q;
    assign err          = err_q;
    assign ovr          = ovr_q;

    // RAM data arrives one cycle after the read strobe, so during FEED the
    // operands pass straight from the RAM read ports to the MAC.
    assign mac_op1 = (state == S_FEED) ? coef_rdata : '0;
    assign mac_op2 = (state == S_FEED) ? smp_rdata :
                     (state == S_INIT) ? init_q    : '0;

endmodule

// File: tb/tb_mac_sequencer.sv
module tb_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [8:0]  ntaps;
    logic [7:0]  coef_base;
    logic [7:0]  smp_base;
    logic [31:0] init_val;
    logic        busy;
    logic        coef_rd_en;
    logic [7:0]  coef_addr;
    logic [31:0] coef_rdata = '0;
    logic        smp_rd_en;
    logic [7:0]  smp_addr;
    logic [31:0] smp_rdata = '0;
    logic        mac_cen, mac_init, mac_load, mac_res_err;
    logic [31:0] mac_op1, mac_op2;
    logic [31:0] mac_out_res;
    logic        mac_acc_ovr;
    logic [31:0] result, err;
    logic        ovr, result_valid;

    mac_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .ntaps(ntaps),
        .coef_base(coef_base), .smp_base(smp_base), .init_val(init_val),
        .busy(busy), .coef_rd_en(coef_rd_en), .coef_addr(coef_addr),
        .coef_rdata(coef_rdata), .smp_rd_en(smp_rd_en), .smp_addr(smp_addr),
        .smp_rdata(smp_rdata), .mac_cen(mac_cen), .mac_init(mac_init),
        .mac_load(mac_load), .mac_res_err(mac_res_err), .mac_op1(mac_op1),
        .mac_op2(mac_op2), .mac_out_res(mac_out_res), .mac_acc_ovr(mac_acc_ovr),
        .result(result), .err(err), .ovr(ovr), .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    // RAM models: coef[a] = a, smp[a] = a + 1, one-cycle read latency.
    always @(posedge clk) begin
        if (coef_rd_en) coef_rdata <= 32'(coef_addr);
        if (smp_rd_en)  smp_rdata  <= 32'(smp_addr) + 32'd1;
    end

    // MAC model: two product pipeline stages then accumulate.
    // Quantised result = acc[39:8], residue = acc[7:0].
    logic [63:0] acc = '0, p1 = '0, p2 = '0;
    logic [31:0] res_reg = '0, err_reg = '0;
    always @(posedge clk) begin
        if (mac_cen) begin
            if (mac_init) begin
                acc <= {32'd0, mac_op2};
                p1  <= '0;
                p2  <= '0;
            end else begin
                p1  <= 64'(mac_op1) * 64'(mac_op2);
                p2  <= p1;
                acc <= acc + p2;
            end
            if (mac_load) begin
                res_reg <= acc[39:8];
                err_reg <= {24'd0, acc[7:0]};
            end
        end
    end
    assign mac_out_res = mac_res_err ? res_reg : err_reg;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;
    int done_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] res;
        logic [31:0] er;
        logic        ov;
        int          lat;
        int          acc_edge;
    } exp_t;

    exp_t        res_q[$];
    logic [15:0] addr_q[$];
    exp_t        me;
    logic [15:0] ma;

    // Monitor: checks every read strobe and every result_valid against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (coef_rd_en || smp_rd_en) begin
                if (addr_q.size() == 0) begin
                    check("read_expected", {coef_rd_en, smp_rd_en}, 2'b00);
                end else begin
                    ma = addr_q.pop_front();
                    check("rd_en_pair", {coef_rd_en, smp_rd_en}, 2'b11);
                    check("coef_addr", coef_addr, ma[15:8]);
                    check("smp_addr", smp_addr, ma[7:0]);
                end
            end
            if (result_valid) begin
                done_cnt++;
                if (res_q.size() == 0) begin
                    check("result_valid_expected", result_valid, 1'b0);
                end else begin
                    me = res_q.pop_front();
                    check("result", result, me.res);
                    check("err", err, me.er);
                    check("ovr", ovr, me.ov);
                    check("latency", edge_cnt - me.acc_edge, me.lat);
                    check("busy_at_done", busy, 1'b1);
                end
            end
            if (mac_init || mac_load || mac_res_err)
                check("ctrl_exclusive", $countones({mac_init, mac_load, mac_res_err}), 1);
        end
    end

    task automatic run_job(input int nt, input logic [7:0] cb, input logic [7:0] sb,
                           input logic [31:0] iv, input logic [31:0] er, input logic [31:0] ee,
                           input logic eo, input int lat, input int nreads,
                           input bit push_res, input bit hold);
        exp_t e;
        @(negedge clk);
        ntaps     = 9'(nt);
        coef_base = cb;
        smp_base  = sb;
        init_val  = iv;
        start     = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        if (push_res) begin
            e.res = er; e.er = ee; e.ov = eo; e.lat = lat; e.acc_edge = edge_cnt;
            res_q.push_back(e);
        end
        for (int k = 0; k < nreads; k++)
            addr_q.push_back({cb + 8'(k), sb - 8'(k)});
    endtask

    task automatic wait_done(input string name);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < 400; i++) begin
            if (done_cnt != d0) break;
            @(posedge clk);
        end
        check(name, done_cnt != d0, 1'b1);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctrl"}, {busy, coef_rd_en, smp_rd_en, mac_cen, mac_init, mac_load,
                                mac_res_err, result_valid, ovr}, '0);
        check({name, "_addr"}, {coef_addr, smp_addr}, '0);
        check({name, "_ops"}, {mac_op1, mac_op2}, '0);
        check({name, "_res"}, {result, err}, '0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; ntaps = '0;
        coef_base = '0; smp_base = '0; init_val = '0; mac_acc_ovr = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Basic job: 16*6 + 17*5 + 18*4 + 19*3 + 0x100 = 566
        run_job(4, 8'h10, 8'h05, 32'h100, 32'h2, 32'h36, 1'b0, 11, 4, 1'b1, 1'b0);
        check("init_pulse", mac_init, 1'b1);
        check("init_cen", mac_cen, 1'b1);
        check("init_op2", mac_op2, 32'h100);
        check("init_op1", mac_op1, 32'h0);
        check("busy_after_accept", busy, 1'b1);
        @(posedge clk); #1;
        check("init_one_cycle", mac_init, 1'b0);
        check("feed0_op1", mac_op1, 32'h10);
        check("feed0_op2", mac_op2, 32'h6);
        wait_done("done_basic");

        // Sample address wrap: 0*2 + 1*1 + 2*256 + 3*255 = 1278
        run_job(4, 8'h00, 8'h01, 32'h0, 32'h4, 32'hFE, 1'b0, 11, 4, 1'b1, 1'b0);
        wait_done("done_wrap");

        // No taps: preload only
        run_job(0, 8'h33, 8'h44, 32'h1234, 32'h12, 32'h34, 1'b0, 7, 0, 1'b1, 1'b0);
        check("ntaps0_init", mac_init, 1'b1);
        wait_done("done_ntaps0");

        // Clamp 300 -> 256: sum k*(257-k), k=1..255 = 2828800 = 0x2B2A00
        run_job(300, 8'h00, 8'h00, 32'h0, 32'h2B2A, 32'h0, 1'b0, 263, 256, 1'b1, 1'b0);
        wait_done("done_clamp");

        // Overflow pulse during FEED, then a clean job
        run_job(4, 8'h10, 8'h05, 32'h100, 32'h2, 32'h36, 1'b1, 11, 4, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1 mac_acc_ovr = 1'b1;
        @(posedge clk);
        #1 mac_acc_ovr = 1'b0;
        wait_done("done_ovr");
        run_job(4, 8'h10, 8'h05, 32'h100, 32'h2, 32'h36, 1'b0, 11, 4, 1'b1, 1'b0);
        wait_done("done_ovr_clear");

        // Abort in the third FEED cycle: reads 0..2 only, no result
        run_job(8, 8'h20, 8'h40, 32'h0, 32'h0, 32'h0, 1'b0, 0, 3, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_busy", busy, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check("abort_result_kept", result, 32'h2);
        check("abort_err_kept", err, 32'h36);

        // start held while busy: exactly one job
        run_job(4, 8'h10, 8'h05, 32'h100, 32'h2, 32'h36, 1'b0, 11, 4, 1'b1, 1'b1);
        repeat (7) @(posedge clk);
        #1;
        check("busy_start_held", busy, 1'b1);
        start = 1'b0;
        wait_done("done_start_held");
        repeat (15) @(posedge clk);

        // Reset in the middle of FLUSH
        run_job(4, 8'h10, 8'h05, 32'h100, 32'h0, 32'h0, 1'b0, 0, 4, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_all_zero("rst_mid_flush");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("after_rst");

        // Recovery job
        run_job(4, 8'h00, 8'h01, 32'h0, 32'h4, 32'hFE, 1'b0, 11, 4, 1'b1, 1'b0);
        wait_done("done_recovery");
        repeat (5) @(posedge clk);

        check("res_queue_empty", res_q.size(), 0);
        check("addr_queue_empty", addr_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
- Initiator/controller for the SRC datapath MAC. Drives its cen, mac_init, load, res_err, op1 and op2 inputs, and reads back out_res and acc_ovr.
- On each start request it runs one dot product: coefficient RAM (ascending addresses) against sample RAM (circular buffer, descending addresses).
- It flushes the MAC pipeline, latches the quantised result and error words, and returns them with a one-cycle valid pulse.
- Sits between the polyphase phase controller and the MAC.

Parameters:
DATA_WIDTH, 32, width of operands, result and error words
COEF_AW, 8, coefficient RAM address width
SMP_AW, 8, sample RAM address width (circular buffer depth 2^SMP_AW)
TAPS_W, 9, width of the tap-count input
MAC_LAT, 3, number of flush cycles inserted after the last product

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
start  in  1  request; accepted when start=1 and busy=0
abort  in  1  synchronous cancel of a running job
ntaps  in  TAPS_W  number of products; sampled at accept
coef_base  in  COEF_AW  first coefficient address; sampled at accept
smp_base  in  SMP_AW  newest sample address; sampled at accept
init_val  in  DATA_WIDTH  accumulator preload (bias/rounding); sampled at accept
busy  out  1  job in progress
coef_rd_en  out  1  coefficient RAM read strobe
coef_addr  out  COEF_AW  coefficient RAM address
coef_rdata  in  DATA_WIDTH  coefficient read data, valid 1 cycle after coef_rd_en
smp_rd_en  out  1  sample RAM read strobe
smp_addr  out  SMP_AW  sample RAM address
smp_rdata  in  DATA_WIDTH  sample read data, valid 1 cycle after smp_rd_en
mac_cen  out  1  MAC clock enable
mac_init  out  1  MAC accumulator preload
mac_load  out  1  MAC result latch
mac_res_err  out  1  MAC output select (1 = result, 0 = error)
mac_op1  out  DATA_WIDTH  MAC operand 1 (coefficient)
mac_op2  out  DATA_WIDTH  MAC operand 2 (sample / init value)
mac_out_res  in  DATA_WIDTH  MAC selected output
mac_acc_ovr  in  1  MAC accumulator overflow indicator
result  out  DATA_WIDTH  latched result word
err  out  DATA_WIDTH  latched error (residue) word
ovr  out  1  sticky overflow seen during the job
result_valid  out  1  one-cycle pulse; result/err/ovr valid

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE.
  - All outputs are 0, including result, err and ovr.
  - Address counters are 0.
- FSM states: IDLE -> INIT -> FEED -> FLUSH -> LOAD -> RES -> ERR -> DONE -> IDLE.
- IDLE: busy=0 and all strobes 0. On accept, latch the inputs, clear ovr, and go to INIT.
- Tap count: ntaps > 2^COEF_AW is clamped to 2^COEF_AW.
- INIT (1 cycle):
  - mac_cen=1, mac_init=1, mac_op2=init_val, mac_op1=0.
  - If ntaps > 0, issue read k=0.
  - Next state is FEED if ntaps > 0, otherwise FLUSH.
- Read addressing: read k uses coef_addr = coef_base + k and smp_addr = (smp_base - k) mod 2^SMP_AW. The sample address wraps below 0 to 2^SMP_AW - 1.
- FEED (exactly ntaps cycles, j = 0..ntaps-1):
  - mac_cen=1, mac_op1=coef_rdata, mac_op2=smp_rdata; these are the data from read j.
  - Read j+1 is issued when j+1 < ntaps.
  - The read enables are 0 on the last FEED cycle.
- FLUSH (MAC_LAT cycles): mac_cen=1, op1=op2=0.
- LOAD (1 cycle): mac_cen=1, mac_load=1, operands 0.
- RES (1 cycle): mac_res_err=1, mac_cen=0. The result register captures mac_out_res at the end of the cycle.
- ERR (1 cycle): mac_res_err=0. The err register captures mac_out_res at the end of the cycle.
- DONE (1 cycle): result_valid=1, busy=1. The next state is IDLE, so busy=0 in the following cycle.
- busy: 1 in every state except IDLE. start while busy=1 is ignored.
- ovr: set to 1 at the end of any FEED/FLUSH/LOAD cycle with mac_acc_ovr=1. Cleared only on accept or reset.
- Latency: result_valid is high N + MAC_LAT + 4 cycles after the accept edge, where N is the clamped ntaps.
- mac_init, mac_load and mac_res_err=1 are never asserted simultaneously.
- abort=1 in any non-IDLE state:
  - Next state is IDLE and all strobes go to 0 in that cycle.
  - No result_valid pulse.
  - result and err keep their previous values.
  - abort has priority over start in the same cycle; abort in IDLE has no effect.
- result and err hold their values until the next DONE.
- rst asserted mid-job returns to IDLE immediately, with all outputs 0.

Test Plan:
- ntaps=4, coef_base=0x10, smp_base=0x05, init_val=0x100, MAC_LAT=3:
  - coef_addr must step 0x10..0x13 and smp_addr 0x05..0x02.
  - mac_init pulses one cycle before the first FEED.
  - result_valid must be high exactly 11 cycles after the accept edge.
- smp_base=0x01, ntaps=4: smp_addr sequence must be 0x01, 0x00, 0xFF, 0xFE (wrap).
- ntaps=0: no read strobes, INIT -> FLUSH directly, result_valid 7 cycles after accept.
- ntaps=300: clamped to 256; exactly 256 FEED cycles; result_valid at 263 cycles.
- mac_acc_ovr pulsed for one cycle during FEED:
  - ovr=1 at result_valid.
  - The next job without overflow must show ovr=0.
- Abort and reset:
  - abort in cycle 3 of FEED: busy=0 next cycle, no result_valid, result/err unchanged.
  - rst mid-FLUSH: all outputs 0 immediately (asynchronously).
  - start held during busy: no second job until DONE.
